prefetch_unit: RTL and testbench

Code prefetch sequencer sitting in front of the bus interface unit's code port. It autonomously issues sequential 32-bit code fetches, buffers returned words in a small queue, and presents them to the instruction decoder with a valid/ready handshake. On a control transfer (flush) it drops queued words and any in-flight bus result, then restarts fetching at the new address.

---
 rtl/prefetch_pkg.sv | 28 ++
 rtl/prefetch_if.sv | 37 +++
 rtl/prefetch_queue.sv | 73 +++++++
 rtl/prefetch_unit.sv | 119 +++++++++++
 tb/tb_prefetch_unit.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/prefetch_pkg.sv
// prefetch_pkg
// Shared definitions for the code prefetch sequencer:
//   fetch_state_t          fetch FSM state encoding (IDLE, FETCH, DISCARD)
//   DEFAULT_RESET_ADDRESS  first fetch address after reset
//   WORD_BYTES             size of one code word in bytes
//   queue_entry_t          {address, data} pair stored per queue entry
//   word_align()           clears the byte-offset bits of a linear address
package prefetch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_ADDRESS = 32'hFFFF_FFF0;
  localparam logic [31:0] WORD_BYTES            = 32'd4;

  typedef struct packed {
    logic [31:0] address;
    logic [31:0] data;
  } queue_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] address);
    return address & ~(WORD_BYTES - 32'd1);
  endfunction

endpackage

// File: rtl/prefetch_if.sv
// prefetch_if
// Bundles the flush, bus-interface-unit code port and decoder queue port of
// the prefetch unit.
//   master modport : the prefetch unit (drives o_* signals)
//   slave modport  : the surrounding core / BIU / decoder (drives i_* signals)
// Parameter QUEUE_DEPTH sizes o_queue_count to $clog2(QUEUE_DEPTH)+1 bits.
interface prefetch_if #(
  parameter int QUEUE_DEPTH = 4
) ();

  localparam int COUNT_W = $clog2(QUEUE_DEPTH) + 1;

  logic               i_flush;
  logic [31:0]        i_flush_address;
  logic               o_code_vaild;
  logic               i_code_ready;
  logic [31:0]        o_code_address;
  logic [31:0]        i_code_data_read;
  logic               o_queue_vaild;
  logic               i_queue_ready;
  logic [31:0]        o_queue_data;
  logic [31:0]        o_queue_address;
  logic [COUNT_W-1:0] o_queue_count;

  modport master (
    input  i_flush, i_flush_address, i_code_ready, i_code_data_read, i_queue_ready,
    output o_code_vaild, o_code_address, o_queue_vaild, o_queue_data,
           o_queue_address, o_queue_count
  );

  modport slave (
    output i_flush, i_flush_address, i_code_ready, i_code_data_read, i_queue_ready,
    input  o_code_vaild, o_code_address, o_queue_vaild, o_queue_data,
           o_queue_address, o_queue_count
  );

endinterface

// File: rtl/prefetch_queue.sv
// prefetch_queue
// Circular buffer of fetched code words, each stored with its address.
//   i_clock, i_reset : clock, asynchronous active-high reset
//   flush            : empties the queue (priority over push and pop)
//   push, push_entry : write one {address, data} entry at the tail
//   pop              : drop the head entry; ignored while empty
//   head_valid       : queue holds at least one entry
//   head_entry       : head {address, data}, straight from storage
//   count            : number of occupied entries
module prefetch_queue
  import prefetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     flush,
  input  logic                     push,
  input  queue_entry_t             push_entry,
  input  logic                     pop,
  output logic                     head_valid,
  output queue_entry_t             head_entry,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int COUNT_W = PTR_W + 1;

  queue_entry_t       mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [COUNT_W-1:0] count_q;
  logic               do_pop;
  logic               do_push;

  // A push into a full queue is only legal when the head leaves on the same edge.
  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != COUNT_W'(DEPTH)) || do_pop);

  // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_valid = (count_q != '0);
  assign head_entry = mem[rd_ptr];
  assign count      = count_q;

endmodule

// File: rtl/prefetch_unit.sv
// prefetch_unit
// Code prefetch sequencer in front of the BIU code port. Issues sequential
// word fetches while the queue has room, queues returned words with their
// addresses and hands them to the decoder with a valid/ready handshake.
// A flush empties the queue, drops any in-flight result and restarts
// fetching at the new address.
//   i_clock, i_reset : clock, asynchronous active-high reset
//   bus (master)     : flush inputs, BIU code port, decoder queue port
// Parameters: QUEUE_DEPTH (power of two, >= 2), RESET_ADDRESS.
// Optional feature macro PREFETCH_BYPASS_EN: forwards a returning word
// straight to the decoder outputs when the queue is empty.
module prefetch_unit
  import prefetch_pkg::*;
#(
  parameter int          QUEUE_DEPTH   = 4,
  parameter logic [31:0] RESET_ADDRESS = DEFAULT_RESET_ADDRESS
) (
  input  logic       i_clock,
  input  logic       i_reset,
  prefetch_if.master bus
);

  localparam int COUNT_W = $clog2(QUEUE_DEPTH) + 1;

  fetch_state_t       state;
  logic [31:0]        fetch_ptr;
  logic [31:0]        code_address;
  logic               accept_word;
  logic               push_store;
  logic               pop;
  logic               q_valid;
  queue_entry_t       q_head;
  logic [COUNT_W-1:0] q_count;

  // A returning word is kept only if it belongs to a live (not discarded) fetch
  // and no flush arrives in the same cycle.
  assign accept_word = (state == FETCH) && bus.i_code_ready && !bus.i_flush;
  assign pop         = q_valid && bus.i_queue_ready;

`ifdef PREFETCH_BYPASS_EN
  logic bypass_hit;
  // Empty queue: the returning word is shown to the decoder immediately, and
  // is only written if the decoder does not take it in that same cycle.
  assign bypass_hit = accept_word && (q_count == '0);
  assign push_store = accept_word && !(bypass_hit && bus.i_queue_ready);
`else
  assign push_store = accept_word;
`endif

  prefetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .flush      (bus.i_flush),
    .push       (push_store),
    .push_entry ('{address: code_address, data: bus.i_code_data_read}),
    .pop        (pop),
    .head_valid (q_valid),
    .head_entry (q_head),
    .count      (q_count)
  );

  // Fetch FSM. Only one fetch is ever outstanding, and IDLE only starts a new
  // one when the queue has a free slot for its result. A flush during FETCH
  // cannot cancel the bus cycle, so DISCARD waits for it to finish.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state        <= IDLE;
      fetch_ptr    <= word_align(RESET_ADDRESS);
      code_address <= word_align(RESET_ADDRESS);
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_flush) begin
            fetch_ptr <= word_align(bus.i_flush_address);
          end else if (q_count < COUNT_W'(QUEUE_DEPTH)) begin
            state        <= FETCH;
            code_address <= fetch_ptr;
          end
        end
        FETCH: begin
          if (bus.i_flush) begin
            fetch_ptr <= word_align(bus.i_flush_address);
            state     <= bus.i_code_ready ? IDLE : DISCARD;
          end else if (bus.i_code_ready) begin
            fetch_ptr <= fetch_ptr + WORD_BYTES;
            state     <= IDLE;
          end
        end
        DISCARD: begin
          if (bus.i_flush) begin
            fetch_ptr <= word_align(bus.i_flush_address);
          end
          if (bus.i_code_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Dropped in the completion cycle so the BIU never sees a stale request.
  assign bus.o_code_vaild   = (state == FETCH) && !bus.i_code_ready;
  assign bus.o_code_address = code_address;
  assign bus.o_queue_count  = q_count;

`ifdef PREFETCH_BYPASS_EN
  assign bus.o_queue_vaild   = q_valid || bypass_hit;
  assign bus.o_queue_data    = bypass_hit ? bus.i_code_data_read : q_head.data;
  assign bus.o_queue_address = bypass_hit ? code_address : q_head.address;
`else
  assign bus.o_queue_vaild   = q_valid;
  assign bus.o_queue_data    = q_head.data;
  assign bus.o_queue_address = q_head.address;
`endif

endmodule

// File: tb/tb_prefetch_unit.sv
// tb_prefetch_unit
// Self-checking bench for prefetch_unit (QUEUE_DEPTH=4, default reset address).
// A bus responder answers each fetch after a programmable latency with data
// derived from the address; a transaction-level model (expected queue of
// addresses, expected next fetch address, outstanding/doomed fetch flags)
// is compared against the DUT on every cycle, and directed scenarios pin
// exact cycles and addresses with literal values.
// Build with PREFETCH_BYPASS_EN defined to exercise the bypass variant.
module tb_prefetch_unit;

  localparam int DEPTH = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;

  prefetch_if #(.QUEUE_DEPTH(DEPTH)) bus ();

  prefetch_unit #(
    .QUEUE_DEPTH   (DEPTH),
    .RESET_ADDRESS (32'hFFFF_FFF0)
  ) dut (
    .i_clock (clock),
    .i_reset (reset),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int fails  = 0;

  // responder state
  int          latency = 2;
  int          rsp_cnt = 0;
  bit          rsp_busy = 0;
  logic [31:0] rsp_addr = '0;

  // model state
  logic [31:0] mq[$];
  logic [31:0] m_ptr    = 32'hFFFF_FFF0;
  bit          m_out    = 0;
  bit          m_doomed = 0;
  logic [31:0] m_req    = '0;
  bit          m_bypass;
  bit          exp_valid;
  logic [31:0] exp_addr;
  logic [31:0] req_log[$];
  int          req_total = 0;

  function automatic logic [31:0] wordFor(input logic [31:0] a);
    return a ^ 32'h5A5A_3C3C;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic flush, input logic [31:0] flush_address,
                               input logic queue_ready);
    bus.i_flush         = flush;
    bus.i_flush_address = flush_address;
    bus.i_queue_ready   = queue_ready;
  endtask

  task automatic waitCycle();
    @(posedge clock);
    #2;
  endtask

  // BIU model: one outstanding fetch, completion pulse after 'latency' cycles.
  always @(posedge clock) begin
    #1;
    if (reset) begin
      bus.i_code_ready = 1'b0;
      rsp_busy = 0;
    end else begin
      if (bus.i_code_ready) begin
        bus.i_code_ready     = 1'b0;
        bus.i_code_data_read = 32'hDEAD_BEEF;
        rsp_busy = 0;
      end else if (rsp_busy) begin
        rsp_cnt--;
        if (rsp_cnt <= 0) begin
          bus.i_code_ready     = 1'b1;
          bus.i_code_data_read = wordFor(rsp_addr);
        end
      end
      if (!rsp_busy && bus.o_code_vaild) begin
        rsp_busy = 1;
        rsp_addr = bus.o_code_address;
        rsp_cnt  = (latency < 1) ? 1 : latency;
      end
    end
  end

  // Per-cycle comparison against the transaction model, then advance the model
  // by what the coming clock edge must do.
  always @(negedge clock) begin
    if (!reset) begin
      m_bypass = 0;
`ifdef PREFETCH_BYPASS_EN
      m_bypass = (mq.size() == 0) && bus.i_code_ready && m_out && !m_doomed && !bus.i_flush;
`endif
      if (bus.o_code_vaild) begin
        if (!m_out) begin
          checkOutput("req_addr", bus.o_code_address, m_ptr);
          checkOutput("req_room", 32'(mq.size() < DEPTH), 32'd1);
          m_out    = 1;
          m_doomed = 0;
          m_req    = bus.o_code_address;
          req_log.push_back(bus.o_code_address);
          req_total++;
        end else begin
          checkOutput("req_while_discard", 32'(m_doomed), 32'd0);
          checkOutput("req_stable", bus.o_code_address, m_req);
        end
      end
      if (bus.i_code_ready) begin
        checkOutput("req_low_on_ready", 32'(bus.o_code_vaild), 32'd0);
      end

      exp_valid = m_bypass || (mq.size() != 0);
      exp_addr  = m_bypass ? m_req : ((mq.size() != 0) ? mq[0] : 32'h0);
      checkOutput("q_valid", 32'(bus.o_queue_vaild), 32'(exp_valid));
      checkOutput("q_count", 32'(bus.o_queue_count), 32'(mq.size()));
      if (exp_valid) begin
        checkOutput("q_addr", bus.o_queue_address, exp_addr);
        checkOutput("q_data", bus.o_queue_data, wordFor(exp_addr));
      end

      if (bus.i_flush) begin
        mq.delete();
        m_ptr = bus.i_flush_address & ~32'h3;
        if (bus.i_code_ready) begin
          m_out    = 0;
          m_doomed = 0;
        end else if (m_out) begin
          m_doomed = 1;
        end
      end else begin
        if ((mq.size() != 0) && bus.i_queue_ready) begin
          void'(mq.pop_front());
        end
        if (bus.i_code_ready && m_out) begin
          if (!m_doomed) begin
            if (!(m_bypass && bus.i_queue_ready)) begin
              mq.push_back(m_req);
            end
            m_ptr = m_req + 32'd4;
          end
          m_out    = 0;
          m_doomed = 0;
        end
      end
    end
  end

  initial begin
    int n;
    int base;
    bus.i_code_ready     = 1'b0;
    bus.i_code_data_read = 32'hDEAD_BEEF;
    applyStimulus(1'b0, 32'h0, 1'b0);

    // Reset values
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("rst_code_vaild", 32'(bus.o_code_vaild), 32'd0);
    checkOutput("rst_code_address", bus.o_code_address, 32'hFFFF_FFF0);
    checkOutput("rst_queue_vaild", 32'(bus.o_queue_vaild), 32'd0);
    checkOutput("rst_queue_data", bus.o_queue_data, 32'h0);
    checkOutput("rst_queue_address", bus.o_queue_address, 32'h0);
    checkOutput("rst_queue_count", 32'(bus.o_queue_count), 32'd0);

    // Sequential fetch from reset with wrap, decoder always ready
    waitCycle();
    reset = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b1);
    @(negedge clock);
    checkOutput("first_req_not_yet", 32'(bus.o_code_vaild), 32'd0);
    @(negedge clock);
    checkOutput("first_req_up", 32'(bus.o_code_vaild), 32'd1);
    checkOutput("first_req_addr", bus.o_code_address, 32'hFFFF_FFF0);
    n = 0;
    while (req_log.size() < 5 && n < 100) begin waitCycle(); n++; end
    checkOutput("seq_req_count", 32'(req_log.size() >= 5), 32'd1);
    if (req_log.size() >= 5) begin
      checkOutput("seq_req0", req_log[0], 32'hFFFF_FFF0);
      checkOutput("seq_req1", req_log[1], 32'hFFFF_FFF4);
      checkOutput("seq_req2", req_log[2], 32'hFFFF_FFF8);
      checkOutput("seq_req3", req_log[3], 32'hFFFF_FFFC);
      checkOutput("seq_req4_wrap", req_log[4], 32'h0000_0000);
    end

    // Decoder stalls: exactly DEPTH fetches, then one more per pop
    applyStimulus(1'b1, 32'h0000_0100, 1'b0);
    waitCycle();
    applyStimulus(1'b0, 32'h0, 1'b0);
    base = req_total;
    repeat (60) waitCycle();
    @(negedge clock);
    checkOutput("full_fetches", 32'(req_total - base), 32'd4);
    checkOutput("full_count", 32'(bus.o_queue_count), 32'd4);
    checkOutput("full_no_req", 32'(bus.o_code_vaild), 32'd0);
    checkOutput("full_head", bus.o_queue_address, 32'h0000_0100);
    waitCycle();
    applyStimulus(1'b0, 32'h0, 1'b1);
    waitCycle();
    applyStimulus(1'b0, 32'h0, 1'b0);
    repeat (30) waitCycle();
    @(negedge clock);
    checkOutput("pop_one_fetch", 32'(req_total - base), 32'd5);
    checkOutput("pop_refill_addr", req_log[req_log.size()-1], 32'h0000_0110);
    checkOutput("pop_count", 32'(bus.o_queue_count), 32'd4);
    checkOutput("pop_head", bus.o_queue_address, 32'h0000_0104);

    // Flush during FETCH, bus completes 3 cycles later into DISCARD
    latency = 3;
    waitCycle();
    applyStimulus(1'b0, 32'h0, 1'b1);
    waitCycle();
    applyStimulus(1'b0, 32'h0, 1'b0);
    n = 0;
    while (!bus.o_code_vaild && n < 20) begin waitCycle(); n++; end
    checkOutput("disc_req_seen", 32'(bus.o_code_vaild), 32'd1);
    applyStimulus(1'b1, 32'h0000_1003, 1'b0);
    waitCycle();
    applyStimulus(1'b0, 32'h0, 1'b0);
    @(negedge clock);
    checkOutput("disc_count_cleared", 32'(bus.o_queue_count), 32'd0);
    checkOutput("disc_req_low", 32'(bus.o_code_vaild), 32'd0);
    waitCycle();
    waitCycle();
    waitCycle();
    @(negedge clock);
    checkOutput("disc_word_dropped", 32'(bus.o_queue_count), 32'd0);
    checkOutput("disc_idle_gap", 32'(bus.o_code_vaild), 32'd0);
    waitCycle();
    @(negedge clock);
    checkOutput("disc_restart", 32'(bus.o_code_vaild), 32'd1);
    checkOutput("disc_restart_addr", bus.o_code_address, 32'h0000_1000);

    // Flush coinciding with bus completion: no DISCARD
    latency = 2;
    n = 0;
    while (bus.o_code_vaild && n < 20) begin waitCycle(); n++; end
    while (!bus.o_code_vaild && n < 40) begin waitCycle(); n++; end
    checkOutput("same_req_seen", 32'(bus.o_code_vaild), 32'd1);
    waitCycle();
    waitCycle();
    applyStimulus(1'b1, 32'h0000_2000, 1'b0);
    waitCycle();
    applyStimulus(1'b0, 32'h0, 1'b0);
    @(negedge clock);
    checkOutput("same_req_low", 32'(bus.o_code_vaild), 32'd0);
    checkOutput("same_count", 32'(bus.o_queue_count), 32'd0);
    waitCycle();
    @(negedge clock);
    checkOutput("same_restart", 32'(bus.o_code_vaild), 32'd1);
    checkOutput("same_restart_addr", bus.o_code_address, 32'h0000_2000);

    // Pop and push in the same cycle with two entries queued
    n = 0;
    while (!(bus.o_queue_count == 3'd2 && bus.i_code_ready) && n < 50) begin waitCycle(); n++; end
    checkOutput("pp_setup", 32'(bus.o_queue_count == 3'd2 && bus.i_code_ready), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    waitCycle();
    applyStimulus(1'b0, 32'h0, 1'b0);
    @(negedge clock);
    checkOutput("pp_count", 32'(bus.o_queue_count), 32'd2);
    checkOutput("pp_head", bus.o_queue_address, 32'h0000_2004);
    waitCycle();
    applyStimulus(1'b0, 32'h0, 1'b1);
    waitCycle();
    applyStimulus(1'b0, 32'h0, 1'b0);
    @(negedge clock);
    checkOutput("pp_order", bus.o_queue_address, 32'h0000_2008);

    // Word returning into an empty queue with the decoder ready
    applyStimulus(1'b1, 32'h0000_3000, 1'b1);
    waitCycle();
    applyStimulus(1'b0, 32'h0, 1'b1);
    n = 0;
    while (!(bus.i_code_ready && !m_doomed && mq.size() == 0) && n < 30) begin waitCycle(); n++; end
    checkOutput("empty_ready_seen", 32'(bus.i_code_ready), 32'd1);
    @(negedge clock);
`ifdef PREFETCH_BYPASS_EN
    checkOutput("byp_valid", 32'(bus.o_queue_vaild), 32'd1);
    checkOutput("byp_addr", bus.o_queue_address, 32'h0000_3000);
    checkOutput("byp_data", bus.o_queue_data, wordFor(32'h0000_3000));
    checkOutput("byp_count", 32'(bus.o_queue_count), 32'd0);
    waitCycle();
    @(negedge clock);
    checkOutput("byp_not_written", 32'(bus.o_queue_count), 32'd0);
`else
    checkOutput("lat_not_yet", 32'(bus.o_queue_vaild), 32'd0);
    waitCycle();
    @(negedge clock);
    checkOutput("lat_valid", 32'(bus.o_queue_vaild), 32'd1);
    checkOutput("lat_addr", bus.o_queue_address, 32'h0000_3000);
    checkOutput("lat_data", bus.o_queue_data, wordFor(32'h0000_3000));
`endif

    repeat (10) waitCycle();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
